urv_csr_file: RTL and testbench
===============================

Name: urv_csr_file

Overview:
Parametrised CSR unit for the uRV execute stage. It reads CSRs combinationally and computes the CSRRW/RS/RC/(I) write value. It owns the mscratch bank and the cycle/instret counters. It flags illegal CSR accesses. Trap-related CSRs (mstatus, mie, mip, mepc, mcause) stay external: they are read through input ports and written by consumers of x_csr_write_value_o.

Parameters:
g_counter_width, 40, width of the cycle and instret counters (legal range 33..64); high halves return bits [W-1:32], zero-extended.
g_num_scratch, 1, number of scratch registers (1..4); scratch 0 is at 0x340, scratch n>0 is at 0x7C0+n-1.
g_with_instret, 1, 1 instantiates the instret counter; 0 makes instret addresses read 0 and remain legal.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
x_stall_i  in  1  execute stage stalled
x_kill_i  in  1  execute stage instruction killed
x_retire_i  in  1  one instruction retired this cycle
d_is_csr_i  in  1  CSR instruction present
d_fun_i  in  3  funct3 (CSRRW=001, RS=010, RC=011, RWI=101, RSI=110, RCI=111)
d_csr_imm_i  in  5  zimm field
d_rs1_idx_i  in  5  rs1 register index
d_csr_sel_i  in  12  CSR address
d_rs1_i  in  32  rs1 value
csr_time_i  in  g_counter_width  external time
csr_mstatus_i, csr_mip_i, csr_mie_i, csr_mepc_i, csr_mcause_i  in  32 each  external CSR values
x_rd_o  out  32  old CSR value (combinational)
x_csr_write_value_o  out  32  new CSR value (combinational)
x_csr_write_o  out  1  CSR write commits this cycle
x_csr_illegal_o  out  1  illegal access (combinational, qualified by d_is_csr_i)
csr_cycles_o, csr_instret_o  out  g_counter_width  counter values

Behaviour:
- Reset (asynchronous, rst_i=0): all scratch registers, cycle counter and instret counter go to 0. x_csr_write_o=0 and x_csr_illegal_o=0 while d_is_csr_i=0.
- Address map:
  - 0xC00/0xC80 cycle lo/hi, read-only
  - 0xC01/0xC81 time lo/hi, read-only
  - 0xC02/0xC82 instret lo/hi, read-only
  - 0xB00/0xB80 mcycle lo/hi, read-write
  - 0xB02/0xB82 minstret lo/hi, read-write
  - 0x300 mstatus, 0x304 mie, 0x341 mepc, 0x342 mcause, 0x344 mip
  - scratch addresses as given under g_num_scratch
  - any other address is unmapped and reads 0
- Operand: the immediate forms use {27'b0, d_csr_imm_i}; the register forms use d_rs1_i.
- Write value: RW gives the operand; RS gives old | operand; RC gives old & ~operand. Reserved funct3 (000, 100) gives write value 0 and is illegal.
- Write intent: RW/RWI always write. RS/RC write only if d_rs1_idx_i != 0. RSI/RCI write only if d_csr_imm_i != 0.
- Illegal: unmapped address; reserved funct3; or write intent to an address with [11:10]==2'b11.
- Commit: x_csr_write_o = d_is_csr_i & write intent & !illegal & !x_stall_i & !x_kill_i. Internal registers update only on the commit edge.
- Cycle counter:
  - Increments by 1 every clock and wraps modulo 2^W.
  - A committed write to mcycle lo replaces bits [31:0]; a write to hi replaces bits [W-1:32] with the truncated write value.
  - A write in the same cycle as an increment: the written half takes the write value, the other half keeps its pre-increment value, and no increment happens that cycle.
- Instret: increments on x_retire_i; write/increment collision rules are the same as for the cycle counter. Wraps modulo 2^W.
- Stall: while x_stall_i=1 nothing commits, but the counters keep counting.
- Reset mid-operation clears state immediately; no pending write survives.

Test Plan:
1. Release reset, wait 10 clocks, CSRRS x0 to 0xC00 -> x_rd_o=10±1 and x_csr_write_o=0; CSRRS x0 to 0xC80 -> 0.
2. CSRRW 0x340 with rs1=0xDEADBEEF, then CSRRC with rs1=0x0000FFFF -> reads 0xDEADBEEF, then 0xDEAD0000 is stored; with g_num_scratch=2, 0x7C0 behaves independently.
3. CSRRW mcycle lo=0xFFFFFFFF, hi=0xFF (W=40) -> the counter wraps to 0 two cycles later; the write cycle shows no increment.
4. CSRRWI 0xC00 -> x_csr_illegal_o=1, no write. CSRRS 0xC00 with rs1 index 0 -> legal. Address 0x123 -> illegal, x_rd_o=0.
5. CSRRW 0x340 with x_kill_i=1, then with x_stall_i=1 -> scratch unchanged; counters still advance.
6. x_retire_i pulsed 5 times while minstret lo is written to 100 on the 3rd pulse -> final instret=102.

Source files
------------

// File: rtl/urv_csr_file.sv
// CSR unit for the uRV execute stage: combinational CSR read/modify, scratch bank,
// cycle/instret counters and illegal-access detection.
module urv_csr_file #(
  parameter int unsigned g_counter_width = 40,
  parameter int unsigned g_num_scratch   = 1,
  parameter int unsigned g_with_instret  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       x_stall_i,
  input  logic                       x_kill_i,
  input  logic                       x_retire_i,
  input  logic                       d_is_csr_i,
  input  logic [2:0]                 d_fun_i,
  input  logic [4:0]                 d_csr_imm_i,
  input  logic [4:0]                 d_rs1_idx_i,
  input  logic [11:0]                d_csr_sel_i,
  input  logic [31:0]                d_rs1_i,
  input  logic [g_counter_width-1:0] csr_time_i,
  input  logic [31:0]                csr_mstatus_i,
  input  logic [31:0]                csr_mip_i,
  input  logic [31:0]                csr_mie_i,
  input  logic [31:0]                csr_mepc_i,
  input  logic [31:0]                csr_mcause_i,
  output logic [31:0]                x_rd_o,
  output logic [31:0]                x_csr_write_value_o,
  output logic                       x_csr_write_o,
  output logic                       x_csr_illegal_o,
  output logic [g_counter_width-1:0] csr_cycles_o,
  output logic [g_counter_width-1:0] csr_instret_o
);

  localparam int unsigned W  = g_counter_width;
  localparam int unsigned HW = W - 32;

  // Scratch 0 lives at mscratch, the rest in the custom 0x7C0 window.
  function automatic logic [11:0] scratch_addr(input int unsigned i);
    return (i == 0) ? 12'h340 : 12'h7C0 + 12'(i - 1);
  endfunction

  logic [W-1:0]  cycle_q, cycle_d;
  logic [W-1:0]  instret_q;
  logic [31:0]   scratch_q [g_num_scratch];
  logic [31:0]   operand, rd, wr_value;
  logic          mapped, wr_intent, illegal, commit;

  always_comb begin
    operand = d_fun_i[2] ? {27'b0, d_csr_imm_i} : d_rs1_i;
    rd      = '0;
    mapped  = 1'b1;
    unique case (d_csr_sel_i)
      12'hC00, 12'hB00: rd = cycle_q[31:0];
      12'hC80, 12'hB80: rd = 32'(cycle_q[W-1:32]);
      12'hC01:          rd = csr_time_i[31:0];
      12'hC81:          rd = 32'(csr_time_i[W-1:32]);
      12'hC02, 12'hB02: rd = instret_q[31:0];
      12'hC82, 12'hB82: rd = 32'(instret_q[W-1:32]);
      12'h300:          rd = csr_mstatus_i;
      12'h304:          rd = csr_mie_i;
      12'h341:          rd = csr_mepc_i;
      12'h342:          rd = csr_mcause_i;
      12'h344:          rd = csr_mip_i;
      default: begin
        mapped = 1'b0;
        for (int unsigned i = 0; i < g_num_scratch; i++) begin
          if (d_csr_sel_i == scratch_addr(i)) begin
            mapped = 1'b1;
            rd     = scratch_q[i];
          end
        end
      end
    endcase

    wr_value  = '0;
    wr_intent = 1'b0;
    unique case (d_fun_i[1:0])
      2'b01: begin
        wr_value  = operand;
        wr_intent = 1'b1;
      end
      2'b10: begin
        wr_value  = rd | operand;
        wr_intent = d_fun_i[2] ? (d_csr_imm_i != 5'd0) : (d_rs1_idx_i != 5'd0);
      end
      2'b11: begin
        wr_value  = rd & ~operand;
        wr_intent = d_fun_i[2] ? (d_csr_imm_i != 5'd0) : (d_rs1_idx_i != 5'd0);
      end
      default: begin
        wr_value  = '0;
        wr_intent = 1'b0;
      end
    endcase

    // Address bits [11:10]==11 mark the read-only CSR space.
    illegal = !mapped || (d_fun_i[1:0] == 2'b00) ||
              (wr_intent && (d_csr_sel_i[11:10] == 2'b11));
    commit  = d_is_csr_i && wr_intent && !illegal && !x_stall_i && !x_kill_i;
  end

  assign x_rd_o              = rd;
  assign x_csr_write_value_o = wr_value;
  assign x_csr_write_o       = commit;
  assign x_csr_illegal_o     = d_is_csr_i && illegal;
  assign csr_cycles_o        = cycle_q;
  assign csr_instret_o       = instret_q;

  // A committed write to either half suppresses that cycle's increment.
  always_comb begin
    cycle_d = cycle_q + W'(1);
    if (commit && d_csr_sel_i == 12'hB00) cycle_d = {cycle_q[W-1:32], wr_value};
    if (commit && d_csr_sel_i == 12'hB80) cycle_d = {wr_value[HW-1:0], cycle_q[31:0]};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_q <= '0;
      for (int unsigned i = 0; i < g_num_scratch; i++) scratch_q[i] <= '0;
    end else begin
      cycle_q <= cycle_d;
      for (int unsigned i = 0; i < g_num_scratch; i++) begin
        if (commit && d_csr_sel_i == scratch_addr(i)) scratch_q[i] <= wr_value;
      end
    end
  end

  if (g_with_instret != 0) begin : g_instret
    logic [W-1:0] instret_d;

    always_comb begin
      instret_d = x_retire_i ? instret_q + W'(1) : instret_q;
      if (commit && d_csr_sel_i == 12'hB02) instret_d = {instret_q[W-1:32], wr_value};
      if (commit && d_csr_sel_i == 12'hB82) instret_d = {wr_value[HW-1:0], instret_q[31:0]};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) instret_q <= '0;
      else        instret_q <= instret_d;
    end
  end else begin : g_no_instret
    assign instret_q = '0;
  end

endmodule

// File: tb/tb_urv_csr_file.sv
// Directed testbench for urv_csr_file (W=40, two scratch registers).
module tb_urv_csr_file;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        x_stall_i = 1'b0, x_kill_i = 1'b0, x_retire_i = 1'b0, d_is_csr_i = 1'b0;
  logic [2:0]  d_fun_i = '0;
  logic [4:0]  d_csr_imm_i = '0, d_rs1_idx_i = '0;
  logic [11:0] d_csr_sel_i = '0;
  logic [31:0] d_rs1_i = '0;
  logic [39:0] csr_time_i = 40'h12_3456_789A;
  logic [31:0] x_rd_o, x_csr_write_value_o;
  logic        x_csr_write_o, x_csr_illegal_o;
  logic [39:0] csr_cycles_o, csr_instret_o;

  int total = 0;
  int bad = 0;

  urv_csr_file #(
    .g_counter_width(40),
    .g_num_scratch  (2),
    .g_with_instret (1)
  ) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .x_stall_i          (x_stall_i),
    .x_kill_i           (x_kill_i),
    .x_retire_i         (x_retire_i),
    .d_is_csr_i         (d_is_csr_i),
    .d_fun_i            (d_fun_i),
    .d_csr_imm_i        (d_csr_imm_i),
    .d_rs1_idx_i        (d_rs1_idx_i),
    .d_csr_sel_i        (d_csr_sel_i),
    .d_rs1_i            (d_rs1_i),
    .csr_time_i         (csr_time_i),
    .csr_mstatus_i      (32'h0000_1888),
    .csr_mip_i          (32'h0000_0080),
    .csr_mie_i          (32'h0000_0800),
    .csr_mepc_i         (32'h0000_1234),
    .csr_mcause_i       (32'h8000_0007),
    .x_rd_o             (x_rd_o),
    .x_csr_write_value_o(x_csr_write_value_o),
    .x_csr_write_o      (x_csr_write_o),
    .x_csr_illegal_o    (x_csr_illegal_o),
    .csr_cycles_o       (csr_cycles_o),
    .csr_instret_o      (csr_instret_o)
  );

  always #10 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a CSR instruction and let combinational outputs settle.
  task automatic drive(input logic [2:0] fun, input logic [11:0] sel, input logic [4:0] idx,
                       input logic [31:0] rs1, input logic [4:0] imm);
    d_is_csr_i  = 1'b1;
    d_fun_i     = fun;
    d_csr_sel_i = sel;
    d_rs1_idx_i = idx;
    d_rs1_i     = rs1;
    d_csr_imm_i = imm;
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    d_is_csr_i = 1'b0;
    x_kill_i   = 1'b0;
    x_stall_i  = 1'b0;
    x_retire_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    #2 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_cycles", 64'(csr_cycles_o), 64'd0);
    chk("rst_instret", 64'(csr_instret_o), 64'd0);
    chk("rst_write", 64'(x_csr_write_o), 64'd0);
    chk("rst_illegal", 64'(x_csr_illegal_o), 64'd0);
    rst_i = 1'b1;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);

    // 1: cycle read after 10 clocks
    drive(3'b010, 12'hC00, 5'd0, 32'hFFFF_FFFF, 5'd0);
    chk("cyc_lo", 64'(x_rd_o), 64'd10);
    chk("cyc_lo_nowrite", 64'(x_csr_write_o), 64'd0);
    chk("cyc_lo_legal", 64'(x_csr_illegal_o), 64'd0);
    drive(3'b010, 12'hC80, 5'd0, 32'h0, 5'd0);
    chk("cyc_hi", 64'(x_rd_o), 64'd0);
    drive(3'b010, 12'hC01, 5'd0, 32'h0, 5'd0);
    chk("time_lo", 64'(x_rd_o), 64'h3456_789A);
    drive(3'b010, 12'h342, 5'd0, 32'h0, 5'd0);
    chk("mcause", 64'(x_rd_o), 64'h8000_0007);
    step();

    // 2: scratch bank
    drive(3'b001, 12'h340, 5'd5, 32'hDEAD_BEEF, 5'd0);
    chk("scr0_rw_old", 64'(x_rd_o), 64'd0);
    chk("scr0_rw_val", 64'(x_csr_write_value_o), 64'hDEAD_BEEF);
    chk("scr0_rw_commit", 64'(x_csr_write_o), 64'd1);
    step();
    drive(3'b011, 12'h340, 5'd6, 32'h0000_FFFF, 5'd0);
    chk("scr0_rc_old", 64'(x_rd_o), 64'hDEAD_BEEF);
    chk("scr0_rc_val", 64'(x_csr_write_value_o), 64'hDEAD_0000);
    step();
    drive(3'b010, 12'h340, 5'd0, 32'h0, 5'd0);
    chk("scr0_stored", 64'(x_rd_o), 64'hDEAD_0000);
    chk("scr0_rs_x0_nowrite", 64'(x_csr_write_o), 64'd0);
    drive(3'b001, 12'h7C0, 5'd1, 32'h1234_5678, 5'd0);
    chk("scr1_old", 64'(x_rd_o), 64'd0);
    step();
    drive(3'b010, 12'h7C0, 5'd0, 32'h0, 5'd0);
    chk("scr1_stored", 64'(x_rd_o), 64'h1234_5678);
    drive(3'b010, 12'h340, 5'd0, 32'h0, 5'd0);
    chk("scr0_indep", 64'(x_rd_o), 64'hDEAD_0000);
    drive(3'b010, 12'h7C1, 5'd0, 32'h0, 5'd0);
    chk("scr_oob_illegal", 64'(x_csr_illegal_o), 64'd1);
    step();

    // 3: mcycle write and wrap
    drive(3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, 5'd0);
    step();
    chk("mcycle_lo_wr", 64'(csr_cycles_o), 64'h00_FFFF_FFFF);
    drive(3'b001, 12'hB80, 5'd1, 32'h0000_00FF, 5'd0);
    step();
    chk("mcycle_hi_wr", 64'(csr_cycles_o), 64'hFF_FFFF_FFFF);
    drive(3'b010, 12'hC80, 5'd0, 32'h0, 5'd0);
    chk("cyc_hi_read", 64'(x_rd_o), 64'hFF);
    d_is_csr_i = 1'b0;
    @(negedge clk_i);
    chk("mcycle_wrap", 64'(csr_cycles_o), 64'd0);

    // 5: kill and stall block commit; counters advance
    x_kill_i = 1'b1;
    drive(3'b001, 12'h340, 5'd1, 32'h1111_1111, 5'd0);
    chk("kill_nowrite", 64'(x_csr_write_o), 64'd0);
    step();
    chk("kill_cyc", 64'(csr_cycles_o), 64'd1);
    x_stall_i = 1'b1;
    drive(3'b001, 12'h340, 5'd1, 32'h2222_2222, 5'd0);
    chk("stall_nowrite", 64'(x_csr_write_o), 64'd0);
    step();
    chk("stall_cyc", 64'(csr_cycles_o), 64'd2);
    drive(3'b010, 12'h340, 5'd0, 32'h0, 5'd0);
    chk("scr0_unchanged", 64'(x_rd_o), 64'hDEAD_0000);

    // 4: illegal accesses
    drive(3'b101, 12'hC00, 5'd0, 32'h0, 5'd3);
    chk("rwi_ro_illegal", 64'(x_csr_illegal_o), 64'd1);
    chk("rwi_ro_nowrite", 64'(x_csr_write_o), 64'd0);
    drive(3'b010, 12'hC00, 5'd0, 32'h0, 5'd0);
    chk("rs_x0_ro_legal", 64'(x_csr_illegal_o), 64'd0);
    drive(3'b010, 12'h123, 5'd0, 32'h0, 5'd0);
    chk("unmapped_illegal", 64'(x_csr_illegal_o), 64'd1);
    chk("unmapped_rd", 64'(x_rd_o), 64'd0);
    drive(3'b100, 12'h340, 5'd1, 32'hFFFF_FFFF, 5'd0);
    chk("resv_illegal", 64'(x_csr_illegal_o), 64'd1);
    chk("resv_val", 64'(x_csr_write_value_o), 64'd0);
    d_is_csr_i = 1'b0;
    d_csr_sel_i = 12'h123;
    #1;
    chk("no_csr_legal", 64'(x_csr_illegal_o), 64'd0);
    step();

    // 6: retire pulses with minstret write on the 3rd
    chk("instret_zero", 64'(csr_instret_o), 64'd0);
    x_retire_i = 1'b1;
    step();
    x_retire_i = 1'b1;
    step();
    chk("instret_two", 64'(csr_instret_o), 64'd2);
    x_retire_i = 1'b1;
    drive(3'b001, 12'hB02, 5'd1, 32'd100, 5'd0);
    step();
    chk("instret_wr", 64'(csr_instret_o), 64'd100);
    x_retire_i = 1'b1;
    step();
    x_retire_i = 1'b1;
    step();
    step();
    chk("instret_final", 64'(csr_instret_o), 64'd102);
    drive(3'b010, 12'hC02, 5'd0, 32'h0, 5'd0);
    chk("instret_read", 64'(x_rd_o), 64'd102);

    // Mid-operation reset discards the pending write
    drive(3'b001, 12'h340, 5'd1, 32'h0000_0055, 5'd0);
    rst_i = 1'b0;
    #1;
    chk("midrst_cycles", 64'(csr_cycles_o), 64'd0);
    chk("midrst_scr0", 64'(x_rd_o), 64'd0);
    @(posedge clk_i);
    #1;
    d_is_csr_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(3'b010, 12'h340, 5'd0, 32'h0, 5'd0);
    chk("midrst_scr0_after", 64'(x_rd_o), 64'd0);
    chk("midrst_instret", 64'(csr_instret_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
